// File: rtl/ingress_ctrl.sv
// ingress_ctrl: staging FIFO between a valid/ready traffic source and the
// flow-control core write port, with an init sequencer after reset.
// Optional statistics counters are enabled with `define INGRESS_STATS_EN.
// Handshake: a source word transfers on a rising edge where
// src_valid && src_ready; src_valid may be held while src_ready is low.
module ingress_ctrl #(
  parameter int DATA_W      = 6,
  parameter int DEPTH       = 4,
  parameter int INIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic              flush,
  input  logic              pause,
  output logic [DATA_W-1:0] data_in,
  output logic              push_main,
  output logic              init,
  output logic              busy,
`ifdef INGRESS_STATS_EN
  output logic [15:0]       push_cnt,
  output logic [15:0]       stall_cnt,
`endif
  output logic [1:0]        st
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int IC_W  = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [IC_W-1:0]   init_cnt;
  logic              accept;
  logic              pop;

  // Room check uses registered count only, so src_ready has no path from src_valid.
  assign src_ready = (count != CNT_W'(DEPTH)) && !flush && !reset_L;
  assign accept    = src_valid && src_ready;
  // Pop reads pre-edge contents, so a word accepted this edge is never popped with it.
  assign pop       = (state == S_RUN) && !pause && (count != '0) && !flush && !reset_L;
  assign busy      = (count != '0) || push_main;
  assign st        = state;

  // Staging storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= src_data;
    end
  end

  // Staging pointers and occupancy; flush and reset empty the FIFO.
  always_ff @(posedge clk) begin
    if (reset_L || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Control FSM: init sequencing after reset, then forwarding gated by pause.
  always_ff @(posedge clk) begin
    if (reset_L) begin
      state     <= S_WAIT;
      init      <= 1'b0;
      init_cnt  <= '0;
      push_main <= 1'b0;
      data_in   <= '0;
    end else begin
      push_main <= 1'b0;
      case (state)
        S_WAIT: begin
          state    <= S_INIT;
          init     <= 1'b1;
          init_cnt <= '0;
        end
        S_INIT: begin
          if (init_cnt == IC_W'(INIT_CYCLES - 1)) begin
            state <= S_RUN;
            init  <= 1'b0;
          end else begin
            init_cnt <= init_cnt + IC_W'(1);
          end
        end
        S_RUN: begin
          if (pause) begin
            state <= S_HOLD;
          end
          if (pop) begin
            data_in   <= mem[rd_ptr];
            push_main <= 1'b1;
          end
        end
        S_HOLD: begin
          if (!pause) begin
            state <= S_RUN;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

`ifdef INGRESS_STATS_EN
  // Saturating push and stall counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset_L) begin
      push_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (push_main && (push_cnt != 16'hFFFF)) begin
        push_cnt <= push_cnt + 16'd1;
      end
      if ((state == S_HOLD) && (count != '0) && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ingress_ctrl.sv
// Testbench for ingress_ctrl: directed vectors, expected words queued at
// acceptance and checked by a monitor whenever push_main is high.
module tb_ingress_ctrl;

  logic       clk;
  logic       reset_L;
  logic [5:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic       flush;
  logic       pause;
  logic [5:0] data_in;
  logic       push_main;
  logic       init;
  logic       busy;
  logic [1:0] st;
`ifdef INGRESS_STATS_EN
  logic [15:0] push_cnt;
  logic [15:0] stall_cnt;
`endif

  int         total = 0;
  int         bad   = 0;
  logic [5:0] exp_q[$];
  logic [5:0] mon_exp;

  ingress_ctrl dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .flush     (flush),
    .pause     (pause),
    .data_in   (data_in),
    .push_main (push_main),
    .init      (init),
    .busy      (busy),
`ifdef INGRESS_STATS_EN
    .push_cnt  (push_cnt),
    .stall_cnt (stall_cnt),
`endif
    .st        (st)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; record expected word if it will transfer.
  task automatic drv(input logic v, input logic [5:0] d, input logic p,
                     input logic f, output logic acc);
    src_valid = v;
    src_data  = d;
    pause     = p;
    flush     = f;
    #1;
    acc = v && src_ready;
    if (f) exp_q.delete();
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic tick_idle(input logic p);
    logic a;
    drv(1'b0, 6'h00, p, 1'b0, a);
  endtask

  // Release reset and check the init pulse window in cycles 2..3.
  task automatic init_seq();
    src_valid = 1'b0;
    pause     = 1'b0;
    flush     = 1'b0;
    reset_L   = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      check("init_pulse", int'(init), int'(c == 2 || c == 3));
      check("init_nopush", int'(push_main), 0);
      check("init_ready", int'(src_ready), 1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    src_valid = 1'b0;
    pause     = 1'b0;
    flush     = 1'b0;
    for (int i = 0; i < 30 && (exp_q.size() != 0 || busy); i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_q", exp_q.size(), 0);
    check("drain_busy", int'(busy), 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (push_main) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_unexpected: got push data_in=%0h want no push", data_in);
      end else begin
        mon_exp = exp_q.pop_front();
        check("mon_data", int'(data_in), int'(mon_exp));
      end
    end
  end

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    reset_L   = 1'b1;
    src_valid = 1'b0;
    src_data  = '0;
    flush     = 1'b0;
    pause     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_push", int'(push_main), 0);
    check("rst_data", int'(data_in), 0);
    check("rst_init", int'(init), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(src_ready), 0);
    check("rst_st", int'(st), 0);

    // reset then idle
    init_seq();
    check("st_run", int'(st), 2);

    // stream 0x01..0x08, one per cycle
    for (int i = 1; i <= 8; i++) begin
      drv(1'b1, 6'(i), 1'b0, 1'b0, a);
      check("stream_acc", int'(a), 1);
      if (i >= 2) check("stream_rate", int'(push_main), 1);
    end
    drv(1'b0, 6'h00, 1'b0, 1'b0, a);
    check("stream_last_push", int'(push_main), 1);
    check("stream_last_data", int'(data_in), 8);
    drain();

    // pause for 3 cycles mid-stream
    drv(1'b1, 6'h20, 1'b0, 1'b0, a);
    drv(1'b1, 6'h21, 1'b0, 1'b0, a);
    drv(1'b1, 6'h22, 1'b0, 1'b0, a);
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 6'(8'h23 + k), 1'b1, 1'b0, a);
      check("pause_acc", int'(a), 1);
      check("pause_push0", int'(push_main), 0);
      check("pause_st", int'(st), 3);
    end
    drain();
`ifdef INGRESS_STATS_EN
    check("stall_cnt", int'(stall_cnt), 3);
`endif

    // three words staged in HOLD, flush, then release pause
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 6'(8'h30 + k), 1'b1, 1'b0, a);
      check("hold_acc", int'(a), 1);
    end
    check("hold_busy", int'(busy), 1);
    drv(1'b1, 6'h33, 1'b1, 1'b1, a);
    check("flush_ready", int'(a), 0);
    check("flush_busy", int'(busy), 0);
    for (int k = 0; k < 4; k++) begin
      tick_idle(1'b0);
      check("flush_nopush", int'(push_main), 0);
    end
    check("flush_busy_end", int'(busy), 0);

    // flush in RUN with a pop pending suppresses the push
    drv(1'b1, 6'h15, 1'b1, 1'b0, a);
    drv(1'b1, 6'h16, 1'b1, 1'b0, a);
    tick_idle(1'b0);
    check("run_pend_st", int'(st), 2);
    drv(1'b0, 6'h00, 1'b0, 1'b1, a);
    check("flush_pop", int'(push_main), 0);
    check("flush_pop_busy", int'(busy), 0);
    for (int k = 0; k < 3; k++) begin
      tick_idle(1'b0);
      check("flush_pop_idle", int'(push_main), 0);
    end

    // reset with two words staged in RUN
    drv(1'b1, 6'h2A, 1'b1, 1'b0, a);
    drv(1'b1, 6'h2B, 1'b1, 1'b0, a);
    tick_idle(1'b0);
    check("pre_rst_busy", int'(busy), 1);
    reset_L   = 1'b1;
    src_valid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("mid_rst_push", int'(push_main), 0);
    check("mid_rst_data", int'(data_in), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_st", int'(st), 0);
    check("mid_rst_ready", int'(src_ready), 0);
    @(posedge clk);
    #1;
    init_seq();
    for (int k = 0; k < 4; k++) begin
      tick_idle(1'b0);
      check("post_rst_nopush", int'(push_main), 0);
    end

    // fill staging during init (pause held), full, then back-to-back out
    reset_L = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_L = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 6'(8'h0A + k), 1'b1, 1'b0, a);
      check("fill_acc", int'(a), 1);
    end
    drv(1'b1, 6'h0E, 1'b1, 1'b0, a);
    check("full_ready", int'(a), 0);
    src_valid = 1'b0;
    pause     = 1'b0;
    for (int i = 0; i < 12 && !push_main; i++) begin
      @(posedge clk);
      #1;
    end
    check("b2b_start", int'(push_main), 1);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("b2b_push", int'(push_main), 1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ingress_ctrl.md
# ingress_ctrl

Ingress controller upstream of the flow-control core. It accepts 6-bit words from a traffic source over a valid/ready handshake and holds them in a small staging FIFO. It then drives the core's `data_in`/`push_main` write port, honouring the core's registered `pause` back-pressure. It also sequences the core's `init` pulse after reset, so the core is never pushed before it has been initialised.

## Interface
- `DATA_W`, 6: word width; matches the core's `data_in`.
- `DEPTH`, 4: staging FIFO entries; power of two, ≥2.
- `INIT_CYCLES`, 2: cycles `init` is held high after reset.

- `clk`  in  1  sole clock; all logic on rising edge.
- `reset_L`  in  1  synchronous, active-high reset (asserted when 1, sampled on `clk`).
- `src_data`  in  DATA_W  word from source.
- `src_valid`  in  1  source word valid.
- `src_ready`  out  1  staging has room; a transfer occurs when `src_valid && src_ready` at a rising edge.
- `flush`  in  1  discard all staged words.
- `pause`  in  1  core main-FIFO back-pressure; already one cycle registered inside the core.
- `data_in`  out  DATA_W  word to the core main FIFO (registered).
- `push_main`  out  1  write strobe to the core (registered).
- `init`  out  1  core initialisation pulse (registered).
- `busy`  out  1  staging non-empty or `push_main` high.

## Operation
- State machine `st`: WAIT → INIT → RUN ⇄ HOLD.
  - WAIT: entered on reset. Left one cycle after `reset_L` deasserts.
  - INIT: `init`=1 for exactly `INIT_CYCLES` cycles (counter), then → RUN.
  - RUN: each cycle with `pause`=0 and staging count>0, pop head: `data_in`←head, `push_main`←1. Otherwise `push_main`←0.
  - RUN → HOLD when `pause`=1 is sampled. HOLD → RUN when `pause`=0 is sampled. In HOLD, `push_main`←0 and `data_in` holds its last value.
- Staging FIFO: `DEPTH` entries, read/write pointers of log2(`DEPTH`) bits wrapping modulo `DEPTH`, count of log2(`DEPTH`)+1 bits.
  - `src_ready` = (count≠`DEPTH`) && !`flush` && !`reset_L`. This is combinational from registered state.
  - Words may be accepted in WAIT/INIT/HOLD; they are held until RUN.
- Simultaneous accept and pop: count unchanged, both pointers advance. The word accepted this cycle is never popped the same cycle, because pop reads pre-edge contents.
- Full: `src_ready`=0. Empty in RUN: `push_main`=0, no underflow.
- `flush`=1: pointers and count → 0 next edge. A pop in the same cycle is suppressed, so `push_main`←0. `st` is unchanged. No source transfer can occur, since `src_ready`=0.
- Reset mid-operation: the staged contents are lost and the FIFO and outputs return to reset values. `init` is re-sequenced.
- Reset values: `push_main`=0, `data_in`=0, `init`=0, `busy`=0, `src_ready`=0 while reset is asserted, `st`=WAIT, count=0.

## Timing
- Source-to-core latency: a word accepted at edge N with an empty FIFO in RUN, `pause`=0, appears at `data_in` with `push_main`=1 after edge N+1.
- Pause reaction: `pause` sampled high at edge N → `push_main`=0 after edge N.
  - Because the core registers `pause` internally, one extra word (pushed before edge N) may land after the core's threshold is crossed.
  - The core's almost-full threshold must leave ≥1 slot margin.
- `init` is high in cycles 2..`INIT_CYCLES`+1 after reset release. The first possible `push_main` is the cycle after `init` falls.
- Throughput: one word per cycle sustained when `pause`=0.

## Configuration
- `INGRESS_STATS_EN` defined adds two outputs:
  - `push_cnt[15:0]`: increments on every `push_main`.
  - `stall_cnt[15:0]`: increments each cycle in HOLD with count>0.
  - Both saturate at 16'hFFFF and clear on reset only.
- Undefined: ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset then idle: release reset, `DEPTH`=4, `INIT_CYCLES`=2 → `init`=1 exactly in cycles 2–3 after release, `push_main`=0 throughout, `src_ready`=1 from cycle 1.
- Stream 0x01..0x08 with `src_valid`=1 after init, `pause`=0 → `data_in` sequence 0x01..0x08 in order, one per cycle, each one cycle after acceptance.
- Push 4 words during INIT → `src_ready`=0 on the 5th offered word. After init, words 0x0A,0x0B,0x0C,0x0D are pushed back-to-back.
- `pause`=1 for 3 cycles mid-stream → `push_main`=0 the cycle after `pause` is sampled high and stays 0 for 3 cycles. The stream then resumes with no lost or duplicated word. With stats enabled, `stall_cnt`=3.
- 3 words staged in HOLD, assert `flush` one cycle, release `pause` → no `push_main`, `busy`=0, count=0.
- Assert `reset_L` with 2 words staged during RUN → next cycle `push_main`=0, `data_in`=0, `busy`=0. After release, `init` is pulsed again and the stale words are never emitted.
